// File: rtl/dbx_sym_enc.sv
// dbx_sym_enc: BPC encoder stage 2, DBX planes to variable-length symbols.
// Emits the base word, then one symbol per non-zero plane or zero run.
package ebpc_pkg;
  localparam int DATA_W     = 8;
  localparam int BLOCK_SIZE = 8;
  localparam int P          = BLOCK_SIZE - 1;
  localparam int POS_W      = $clog2(P);
  localparam int ZRL_W      = $clog2(DATA_W);
  localparam int CW_A = (DATA_W > 1 + P) ? DATA_W : 1 + P;
  localparam int CW_B = (5 + POS_W > 3 + ZRL_W) ?
                        5 + POS_W : 3 + ZRL_W;
  localparam int CODE_W = (CW_A > CW_B) ? CW_A : CW_B;
  localparam int LEN_W  = $clog2(CODE_W + 1);
  localparam int IDX_W  = $clog2(DATA_W + 1);
  localparam int RUN_W  = $clog2(DATA_W + 2);
  localparam int CNT_W  = $clog2(P + 1);

  typedef struct packed {
    logic [0:DATA_W][P-1:0] dbp;
    logic [DATA_W-1:0]      base;
  } dbp_block_t;
endpackage

module dbx_sym_enc
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  dbp_block_t        dbp_block_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic              flush_i,
  output logic [CODE_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              flush_o,
  output logic              idle_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BASE,
    S_PLANE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_plane;
  logic [IDX_W-1:0] w_plane_nxt;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  dbp_block_t       r_blk;
  logic             w_load;

  logic [P-1:0]     w_dbp_cur;
  logic [P-1:0]     w_dbp_prv;
  logic [P-1:0]     w_dbx;
  logic             w_last;

  logic [CNT_W-1:0] w_ones;
  logic [POS_W-1:0] w_pos;
  logic             w_adj;

  logic [CODE_W-1:0] w_sym_code;
  logic [LEN_W-1:0]  w_sym_len;
  logic [CODE_W-1:0] w_run_code;
  logic [LEN_W-1:0]  w_run_len;
  logic [RUN_W-1:0]  w_run_m2;

  // DBX of the current plane from the registered block
  always_comb begin
    w_dbp_cur = r_blk.dbp[r_plane];
    w_dbp_prv = '0;
    if (r_plane != '0) begin
      w_dbp_prv = r_blk.dbp[r_plane - 1'b1];
    end
    w_dbx  = w_dbp_cur ^ w_dbp_prv;
    w_last = (r_plane == IDX_W'(DATA_W));
  end

  // popcount, lowest set bit and adjacency of the DBX plane
  always_comb begin
    w_ones = '0;
    w_pos  = '0;
    for (int i = P - 1; i >= 0; i--) begin
      w_ones = w_ones + CNT_W'(w_dbx[i]);
      if (w_dbx[i]) begin
        w_pos = POS_W'(i);
      end
    end
    w_adj = |(w_dbx & (w_dbx >> 1));
  end

  // plane symbol, first matching class wins
  always_comb begin
    w_sym_code = CODE_W'({1'b1, w_dbx});
    w_sym_len  = LEN_W'(1 + P);
    if (&w_dbx) begin
      w_sym_code = CODE_W'(5'b00000);
      w_sym_len  = LEN_W'(5);
    end else if (w_dbp_cur == '0) begin
      w_sym_code = CODE_W'(5'b00001);
      w_sym_len  = LEN_W'(5);
    end else if (w_ones == CNT_W'(2) && w_adj) begin
      w_sym_code = CODE_W'({5'b00010, w_pos});
      w_sym_len  = LEN_W'(5 + POS_W);
    end else if (w_ones == CNT_W'(1)) begin
      w_sym_code = CODE_W'({5'b00011, w_pos});
      w_sym_len  = LEN_W'(5 + POS_W);
    end
  end

  // zero-run symbol for the pending run count
  always_comb begin
    w_run_m2   = r_run - RUN_W'(2);
    w_run_code = CODE_W'(2'b01);
    w_run_len  = LEN_W'(2);
    if (r_run != RUN_W'(1)) begin
      w_run_code = CODE_W'({3'b001, w_run_m2[ZRL_W-1:0]});
      w_run_len  = LEN_W'(3 + ZRL_W);
    end
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_plane_nxt = r_plane;
    w_run_nxt   = r_run;
    w_load      = 1'b0;
    rdy_o       = 1'b0;
    vld_o       = 1'b0;
    data_o      = '0;
    len_o       = '0;
    flush_o     = 1'b0;
    idle_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        rdy_o   = 1'b1;
        idle_o  = ~vld_i;
        flush_o = flush_i & ~vld_i;
        if (vld_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_BASE;
        end
      end
      S_BASE: begin
        vld_o  = 1'b1;
        data_o = CODE_W'(r_blk.base);
        len_o  = LEN_W'(DATA_W);
        if (rdy_i) begin
          w_plane_nxt = '0;
          w_run_nxt   = '0;
          w_state_nxt = S_PLANE;
        end
      end
      S_PLANE: begin
        if (w_dbx == '0) begin
          w_run_nxt = r_run + 1'b1;
          if (w_last) begin
            w_state_nxt = S_RUN;
          end else begin
            w_plane_nxt = r_plane + 1'b1;
          end
        end else if (r_run != '0) begin
          vld_o  = 1'b1;
          data_o = w_run_code;
          len_o  = w_run_len;
          if (rdy_i) begin
            w_run_nxt = '0;
          end
        end else begin
          vld_o  = 1'b1;
          data_o = w_sym_code;
          len_o  = w_sym_len;
          if (rdy_i) begin
            if (w_last) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_plane_nxt = r_plane + 1'b1;
            end
          end
        end
      end
      S_RUN: begin
        vld_o  = 1'b1;
        data_o = w_run_code;
        len_o  = w_run_len;
        if (rdy_i) begin
          w_run_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state, counters and block register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_plane <= '0;
      r_run   <= '0;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_plane <= w_plane_nxt;
      r_run   <= w_run_nxt;
      if (w_load) begin
        r_blk <= dbp_block_i;
      end
    end
  end

endmodule

// File: tb/tb_dbx_sym_enc.sv
// tb_dbx_sym_enc: table-driven bench for dbx_sym_enc.
// Blocks with hand-computed symbol streams, plus stall, flush and reset cases.
module tb_dbx_sym_enc;
  import ebpc_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  dbp_block_t        dbp_block_i;
  logic              vld_i;
  logic              rdy_o;
  logic              flush_i;
  logic [CODE_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic              vld_o;
  logic              rdy_i;
  logic              flush_o;
  logic              idle_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [0:8][6:0] dbp;
    logic [7:0]      base;
    int              n;
    logic [0:9][7:0] code;
    logic [0:9][3:0] len;
  } vec_t;

  vec_t vec[8];

  always #5 clk_i = ~clk_i;

  dbx_sym_enc dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .dbp_block_i (dbp_block_i),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .len_o       (len_o),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .flush_o     (flush_o),
    .idle_o      (idle_o)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add(input int vi, input logic [7:0] c,
                     input logic [3:0] l);
    vec[vi].code[vec[vi].n] = c;
    vec[vi].len[vec[vi].n]  = l;
    vec[vi].n++;
  endtask

  task automatic init_tab();
    for (int i = 0; i < 8; i++) begin
      vec[i].dbp  = '0;
      vec[i].base = '0;
      vec[i].n    = 0;
      vec[i].code = '0;
      vec[i].len  = '0;
    end
    // all zero: base, run of 9
    add(0, 8'h00, 4'd8); add(0, 8'h0F, 4'd6);
    // single one in last plane
    vec[1].dbp[8] = 7'b0000001; vec[1].base = 8'h5A;
    add(1, 8'h5A, 4'd8); add(1, 8'h0E, 4'd6);
    add(1, 8'h18, 4'd8);
    // all-ones DBX twice, then run of 7
    vec[2].dbp[0] = 7'h7F; vec[2].base = 8'h33;
    add(2, 8'h33, 4'd8); add(2, 8'h00, 4'd5);
    add(2, 8'h00, 4'd5); add(2, 8'h0D, 4'd6);
    // adjacent pair, raw plane, zero dbp, run 6
    vec[3].dbp[0] = 7'b0110000; vec[3].dbp[1] = 7'b1010101;
    vec[3].base = 8'hC3;
    add(3, 8'hC3, 4'd8); add(3, 8'h14, 4'd8);
    add(3, 8'hE5, 4'd8); add(3, 8'h01, 4'd5);
    add(3, 8'h0C, 4'd6);
    // run of length 1
    vec[4].dbp[0] = 7'b1010101; vec[4].dbp[1] = 7'b1010101;
    vec[4].base = 8'hFF;
    add(4, 8'hFF, 4'd8); add(4, 8'hD5, 4'd8);
    add(4, 8'h01, 4'd2); add(4, 8'h01, 4'd5);
    add(4, 8'h0C, 4'd6);
    // single one at top bit, run 2, raw plane, run 5
    vec[5].dbp[0] = 7'b1000000; vec[5].dbp[1] = 7'b1000000;
    vec[5].dbp[2] = 7'b1000000;
    for (int j = 3; j < 9; j++) vec[5].dbp[j] = 7'b0000011;
    vec[5].base = 8'h01;
    add(5, 8'h01, 4'd8); add(5, 8'h1E, 4'd8);
    add(5, 8'h08, 4'd6); add(5, 8'hC3, 4'd8);
    add(5, 8'h0B, 4'd6);
    // adjacent pair at bit 0 in the last plane
    vec[6].dbp[8] = 7'b0000011; vec[6].base = 8'h80;
    add(6, 8'h80, 4'd8); add(6, 8'h0E, 4'd6);
    add(6, 8'h10, 4'd8);
    // two non-adjacent ones -> raw, then run 8
    for (int j = 0; j < 9; j++) vec[7].dbp[j] = 7'b0000101;
    add(7, 8'h00, 4'd8); add(7, 8'h85, 4'd8);
    add(7, 8'h0E, 4'd6);
  endtask

  // called on a falling edge with the DUT idle
  task automatic load(input int vi, input logic fl);
    chk("rdy_o_idle", 32'(rdy_o), 32'd1);
    dbp_block_i.dbp  = vec[vi].dbp;
    dbp_block_i.base = vec[vi].base;
    vld_i   = 1'b1;
    flush_i = fl;
    #1;
    chk("flush_o_load", 32'(flush_o), 32'd0);
    chk("idle_o_load", 32'(idle_o), 32'd0);
    @(negedge clk_i);
    vld_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic run_vec(input int vi, input bit stall,
                         input logic fl);
    int k;
    int cyc;
    int held;
    logic [7:0] hd;
    logic [3:0] hl;
    k = 0; cyc = 0; held = 0;
    hd = '0; hl = '0;
    rdy_i = 1'b1;
    load(vi, fl);
    while (k < vec[vi].n && cyc < 200) begin
      if (vld_o) begin
        if (held > 0) begin
          chk("hold_data", 32'(data_o), 32'(hd));
          chk("hold_len", 32'(len_o), 32'(hl));
        end
        if (stall && held < 3) begin
          hd = data_o; hl = len_o;
          rdy_i = 1'b0;
          held++;
        end else begin
          rdy_i = 1'b1;
          chk($sformatf("v%0d_code%0d", vi, k), 32'(data_o),
              32'(vec[vi].code[k]));
          chk($sformatf("v%0d_len%0d", vi, k), 32'(len_o),
              32'(vec[vi].len[k]));
          k++;
          held = 0;
        end
      end else begin
        if (held > 0) chk("hold_vld", 32'(vld_o), 32'd1);
        held  = 0;
        rdy_i = 1'b1;
      end
      @(negedge clk_i);
      cyc++;
    end
    if (k < vec[vi].n) begin
      errors++;
      $display("FAIL timeout_v%0d: got %0d symbols, need %0d",
               vi, k, vec[vi].n);
    end
    rdy_i = 1'b1;
    chk($sformatf("v%0d_idle_after", vi), 32'(idle_o), 32'd1);
    chk($sformatf("v%0d_vld_after", vi), 32'(vld_o), 32'd0);
  endtask

  initial begin
    vld_i = 1'b0;
    flush_i = 1'b0;
    rdy_i = 1'b1;
    dbp_block_i = '0;
    init_tab();
    #1;
    chk("rst_rdy_o", 32'(rdy_o), 32'd1);
    chk("rst_vld_o", 32'(vld_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_len_o", 32'(len_o), 32'd0);
    chk("rst_flush_o", 32'(flush_o), 32'd0);
    chk("rst_idle_o", 32'(idle_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int vi = 0; vi < 8; vi++) run_vec(vi, 1'b0, 1'b0);

    // 3-cycle stalls on every symbol, including the base word
    run_vec(1, 1'b1, 1'b0);
    run_vec(3, 1'b1, 1'b0);

    // flush in idle without a block
    flush_i = 1'b1;
    #1;
    chk("flush_idle", 32'(flush_o), 32'd1);
    chk("flush_idle_idle", 32'(idle_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("flush_drop", 32'(flush_o), 32'd0);
    @(negedge clk_i);

    // flush together with a block is not forwarded
    run_vec(2, 1'b0, 1'b1);

    // reset while emitting plane symbols
    rdy_i = 1'b1;
    load(3, 1'b0);
    @(negedge clk_i);
    chk("mid_plane_vld", 32'(vld_o), 32'd1);
    chk("mid_plane_code", 32'(data_o), 32'h14);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(vld_o), 32'd0);
    chk("rst_mid_idle", 32'(idle_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_vec(1, 1'b0, 1'b0);
    run_vec(4, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
